mem_responder: RTL and testbench

//  Memory-side responder for the multicycle NITCRISC24 control/datapath.

---
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_responder.sv | 96 +++++++++
 tb/tb_mem_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response and preload bundle for mem_responder
interface mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              MemRead;
  logic              MemWrite;
  logic [15:0]       Addr;
  logic [DATA_W-1:0] WriteData;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic [DATA_W-1:0] MemData;
  logic              MemReady;
  logic              MemBusy;
  logic              MemErr;

  modport master (
    output MemRead, MemWrite, Addr, WriteData, init_we, init_addr, init_data,
    input  MemData, MemReady, MemBusy, MemErr
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData, init_we, init_addr, init_data,
    output MemData, MemReady, MemBusy, MemErr
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-stated unified RAM responder with MemReady pulse and preload port
module mem_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  localparam logic [3:0] RD_INIT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_INIT = 4'(WR_LAT - 1);

  state_t            state, state_next;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              oor_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic req_rd, req_wr, req_both, req_oor, done, init_ok;

  always_comb begin
    req_rd   = (state == IDLE) && bus.MemRead && !bus.MemWrite;
    req_wr   = (state == IDLE) && bus.MemWrite && !bus.MemRead;
    req_both = (state == IDLE) && bus.MemWrite && bus.MemRead;
    req_oor  = (bus.Addr >> ADDR_W) != 16'd0;
    done     = ((state == RD_WAIT) || (state == WR_WAIT)) && (cnt == 4'd0);
    // A request at the same edge always wins over preload.
    init_ok  = (state == IDLE) && bus.init_we && !bus.MemRead && !bus.MemWrite;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_rd)      state_next = RD_WAIT;
        else if (req_wr) state_next = WR_WAIT;
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt == 4'd0) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (req_rd) begin
        cnt <= RD_INIT;
      end else if (req_wr) begin
        cnt <= WR_INIT;
      end else if (((state == RD_WAIT) || (state == WR_WAIT)) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (req_rd || req_wr) begin
        addr_q  <= bus.Addr[ADDR_W-1:0];
        oor_q   <= req_oor;
        wdata_q <= bus.WriteData;
      end
      // Error pulse: immediately for a conflicting request, alongside MemReady for out-of-range.
      err_q <= req_both || (done && oor_q);
      if (done && (state == RD_WAIT)) begin
        rdata_q <= oor_q ? '0 : mem[addr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (done && (state == WR_WAIT) && !oor_q) begin
      mem[addr_q] <= wdata_q;
    end else if (init_ok) begin
      mem[bus.init_addr] <= bus.init_data;
    end
  end

  assign bus.MemData  = rdata_q;
  assign bus.MemReady = (state == RESP);
  assign bus.MemBusy  = (state != IDLE);
  assign bus.MemErr   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder
module tb_mem_responder;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  logic [15:0] model [0:255];
  logic [15:0] last_rd;
  int n_checks;
  int n_fail;

  mem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every MemReady must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && bus.MemReady) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", 32'(bus.MemData), 32'(e.data));
        check("sb_err", 32'(bus.MemErr), 32'(e.err));
      end
    end
  end

  function automatic exp_t predict(input bit wr, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    logic oor;
    oor = (a[15:8] != 8'd0);
    e.err = oor;
    if (wr) begin
      if (!oor) model[a[7:0]] = d;
      e.data = last_rd;
    end else begin
      last_rd = oor ? 16'd0 : model[a[7:0]];
      e.data = last_rd;
    end
    return e;
  endfunction

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    bus.init_we   = 1'b1;
    bus.init_addr = a;
    bus.init_data = d;
    model[a]      = d;
    @(negedge clk);
    bus.init_we   = 1'b0;
  endtask

  task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] d);
    int k;
    int busy;
    sb.push_back(predict(wr, a, d));
    bus.MemRead   = !wr;
    bus.MemWrite  = wr;
    bus.Addr      = a;
    bus.WriteData = d;
    @(negedge clk);
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    k = 0;
    busy = bus.MemBusy ? 1 : 0;
    while (!bus.MemReady && k < 20) begin
      @(negedge clk);
      k++;
      if (bus.MemBusy) busy++;
    end
    check(wr ? "wr_latency" : "rd_latency", 32'(k), 32'(wr ? WR_LAT : RD_LAT));
    check("busy_cycles", 32'(busy), 32'((wr ? WR_LAT : RD_LAT) + 1));
    @(negedge clk);
    check("ready_one_cycle", 32'(bus.MemReady), 32'd0);
  endtask

  initial begin
    int t;
    int ready_at[3];
    int nr;
    n_checks = 0;
    n_fail   = 0;
    last_rd  = 16'd0;
    for (int i = 0; i < 256; i++) model[i] = 16'd0;
    reset = 1'b0;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.Addr = 16'd0; bus.WriteData = 16'd0;
    bus.init_we = 1'b0; bus.init_addr = 8'd0; bus.init_data = 16'd0;
    @(negedge clk);
    check("rst_data", 32'(bus.MemData), 32'd0);
    check("rst_ready", 32'(bus.MemReady), 32'd0);
    check("rst_busy", 32'(bus.MemBusy), 32'd0);
    check("rst_err", 32'(bus.MemErr), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    preload(8'd5, 16'hA5A5);
    preload(8'd9, 16'h0000);
    preload(8'd7, 16'h7777);
    access(1'b0, 16'd5, 16'd0);

    access(1'b1, 16'd9, 16'h1234);
    access(1'b0, 16'd9, 16'd0);

    // Conflicting request: error next cycle, no access, no completion.
    bus.MemRead = 1'b1; bus.MemWrite = 1'b1; bus.Addr = 16'd7; bus.WriteData = 16'hDEAD;
    @(negedge clk);
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    check("both_err", 32'(bus.MemErr), 32'd1);
    check("both_ready", 32'(bus.MemReady), 32'd0);
    check("both_busy", 32'(bus.MemBusy), 32'd0);
    @(negedge clk);
    check("both_err_clr", 32'(bus.MemErr), 32'd0);
    access(1'b0, 16'd7, 16'd0);

    access(1'b0, 16'h0100, 16'd0);
    access(1'b1, 16'h0105, 16'hBAD0);
    access(1'b0, 16'd5, 16'd0);
    access(1'b1, 16'd200, 16'hC3C3);
    access(1'b0, 16'd200, 16'd0);

    // Async reset in the middle of a read wait.
    bus.MemRead = 1'b1; bus.Addr = 16'd9;
    @(negedge clk);
    bus.MemRead = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_busy", 32'(bus.MemBusy), 32'd0);
    check("async_data", 32'(bus.MemData), 32'd0);
    check("async_ready", 32'(bus.MemReady), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    last_rd = 16'd0;
    @(negedge clk);
    check("post_rst_idle", 32'(bus.MemBusy), 32'd0);
    access(1'b0, 16'd9, 16'd0);

    // Held MemRead: completions every RD_LAT+2 cycles; init_we never lands.
    for (int i = 0; i < 3; i++) sb.push_back(predict(1'b0, 16'd5, 16'd0));
    bus.MemRead = 1'b1; bus.Addr = 16'd5;
    bus.init_we = 1'b1; bus.init_addr = 8'd5; bus.init_data = 16'hBEEF;
    t = 0; nr = 0;
    while (nr < 3 && t < 60) begin
      @(negedge clk);
      t++;
      if (bus.MemReady) begin
        ready_at[nr] = t;
        nr++;
      end
    end
    bus.MemRead = 1'b0; bus.init_we = 1'b0;
    check("b2b_count", 32'(nr), 32'd3);
    if (nr == 3) begin
      check("b2b_gap0", 32'(ready_at[1] - ready_at[0]), 32'(RD_LAT + 2));
      check("b2b_gap1", 32'(ready_at[2] - ready_at[1]), 32'(RD_LAT + 2));
    end
    @(negedge clk);
    check("b2b_stopped", 32'(bus.MemBusy), 32'd0);
    access(1'b0, 16'd5, 16'd0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
